// File: rtl/fp_arb_pkg.sv
// Shared defaults, tag type and helper for the shared f32 operator arbiter.
// Imported by fp_op_arbiter, rr_arbiter and fp_op_arbiter_if.
package fp_arb_pkg;

    localparam int FP_LATENCY = 12;
    localparam int FP_WIDTH   = 32;
    localparam int FP_NUM_REQ = 4;
    localparam int FP_MAX_REQ = 16;

    // Widest requester tag; narrower instances zero-extend into it.
    typedef logic [FP_MAX_REQ-1:0] tag_t;

    // OR-encoder: exact for one-hot input, zero for an all-zero tag.
    function automatic logic [3:0] onehot_to_idx(input tag_t tag);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < FP_MAX_REQ; i++) begin
            if (tag[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fp_op_arbiter_if.sv
// Requester-side bundle: operand handshake and one-hot response strobe.
// master = requester lanes, slave = the arbiter.
interface fp_op_arbiter_if
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ = FP_NUM_REQ,
    parameter int WIDTH   = FP_WIDTH
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [WIDTH-1:0]         resp_data;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/fp_op_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above the pointer,
// wrapping. The pointer register is owned by the parent.
module rr_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ = FP_NUM_REQ,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    // NOTE: every always_comb output gets a default before any branch, so no path leaves a latch.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_idx]) begin
                w_found          = 1'b1;
                o_grant[w_idx]   = 1'b1;
            end
        end
    end

    assign o_grant_idx = IDX_W'(onehot_to_idx(tag_t'(o_grant)));

endmodule

// File: rtl/fp_op_arbiter.sv
// Shares one fixed-latency pipelined f32 unit among NUM_REQ lanes with a one-hot tag pipe.
// Optional macro FP_ARB_PERF_CNT_EN adds per-requester grant and busy-cycle counters.
module fp_op_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ = FP_NUM_REQ,
    parameter int LATENCY = FP_LATENCY,
    parameter int WIDTH   = FP_WIDTH
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    fp_op_arbiter_if.slave       req_bus,
    output logic                 op_a_tvalid,
    output logic [WIDTH-1:0]     op_a_tdata,
    output logic                 op_b_tvalid,
    output logic [WIDTH-1:0]     op_b_tdata,
    input  logic                 op_result_tvalid,
    input  logic [WIDTH-1:0]     op_result_tdata,
`ifdef FP_ARB_PERF_CNT_EN
    output logic [NUM_REQ*32-1:0] perf_grant_cnt,
    output logic [31:0]           perf_busy_cnt,
`endif
    output logic                 err_mismatch
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int DRAIN_W = $clog2(LATENCY + 1);

    logic [NUM_REQ-1:0] w_arb_grant;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_issue;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic [NUM_REQ-1:0] w_tag_out;
    logic               w_tag_live;

    logic [IDX_W-1:0]   r_ptr;
    logic [DRAIN_W-1:0] r_drain;
    logic [NUM_REQ-1:0] r_tag_pipe [LATENCY];
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [WIDTH-1:0]   r_resp_data;
    logic               r_err;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req       (req_bus.req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_grant_idx)
    );

    // Grant is forced off while reset is held so nothing reaches the unit.
    assign w_grant = aresetn ? w_arb_grant : '0;
    assign w_issue = |w_grant;

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_op_a = w_op_a | req_bus.req_a[i*WIDTH +: WIDTH];
                w_op_b = w_op_b | req_bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_bus.req_ready = w_grant;
    assign op_a_tvalid       = w_issue;
    assign op_b_tvalid       = w_issue;
    assign op_a_tdata        = w_op_a;
    assign op_b_tdata        = w_op_b;

    assign w_tag_out  = r_tag_pipe[LATENCY-1];
    assign w_tag_live = |w_tag_out;

    // NOTE: sequential state is updated with <= only, so every stage sees last cycle's values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ptr   <= '0;
            r_drain <= DRAIN_W'(LATENCY);
        end else begin
            if (w_issue) begin
                r_ptr <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (r_drain != '0) r_drain <= r_drain - 1'b1;
        end
    end

    // NOTE: the tag pipe is reset stage by stage; in-flight tags must vanish on reset
    // or stale unit outputs would be routed back to a requester.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int s = 0; s < LATENCY; s++) r_tag_pipe[s] <= '0;
        end else begin
            r_tag_pipe[0] <= w_grant;
            for (int s = 1; s < LATENCY; s++) r_tag_pipe[s] <= r_tag_pipe[s-1];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_tag_live && op_result_tvalid) begin
                r_resp_valid <= w_tag_out;
                r_resp_data  <= op_result_tdata;
            end else begin
                r_resp_valid <= '0;
            end
            // Outside the drain window valid and tag must agree exactly.
            if (r_drain == '0 && (op_result_tvalid != w_tag_live)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign req_bus.resp_valid = r_resp_valid;
    assign req_bus.resp_data  = r_resp_data;
    assign err_mismatch       = r_err;

`ifdef FP_ARB_PERF_CNT_EN
    logic [31:0] r_grant_cnt [NUM_REQ];
    logic [31:0] r_busy_cnt;
    logic        w_in_flight;

    always_comb begin
        w_in_flight = 1'b0;
        for (int s = 0; s < LATENCY; s++) w_in_flight = w_in_flight | (|r_tag_pipe[s]);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REQ; i++) r_grant_cnt[i] <= '0;
            r_busy_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i] && r_grant_cnt[i] != '1) r_grant_cnt[i] <= r_grant_cnt[i] + 1'b1;
            end
            if (w_in_flight && r_busy_cnt != '1) r_busy_cnt <= r_busy_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        assign perf_grant_cnt[g*32 +: 32] = r_grant_cnt[g];
    end
    assign perf_busy_cnt = r_busy_cnt;
`endif

endmodule

// File: tb/tb_fp_op_arbiter.sv
// Directed bench for fp_op_arbiter with a behavioural f32 adder standing in for the shared unit.
// The adder model has no reset, mimicking stale contents after an arbiter reset.
module tb_fp_op_arbiter;
    import fp_arb_pkg::*;

    localparam int NR  = 4;
    localparam int LAT = 12;
    localparam int W   = 32;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    fp_op_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) req_bus ();

    logic          op_a_tvalid, op_b_tvalid, op_result_tvalid, err_mismatch;
    logic [W-1:0]  op_a_tdata, op_b_tdata, op_result_tdata;
    logic          force_valid = 1'b0;
`ifdef FP_ARB_PERF_CNT_EN
    logic [NR*32-1:0] perf_grant_cnt;
    logic [31:0]      perf_busy_cnt;
`endif

    fp_op_arbiter #(.NUM_REQ(NR), .LATENCY(LAT), .WIDTH(W)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .req_bus          (req_bus),
        .op_a_tvalid      (op_a_tvalid),
        .op_a_tdata       (op_a_tdata),
        .op_b_tvalid      (op_b_tvalid),
        .op_b_tdata       (op_b_tdata),
        .op_result_tvalid (op_result_tvalid),
        .op_result_tdata  (op_result_tdata),
`ifdef FP_ARB_PERF_CNT_EN
        .perf_grant_cnt   (perf_grant_cnt),
        .perf_busy_cnt    (perf_busy_cnt),
`endif
        .err_mismatch     (err_mismatch)
    );

    // Behavioural f32 adder for normal operands with exactly representable sums.
    function automatic real f32_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'({3'b000, f[30:23]}) + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    logic [LAT-1:0] u_v = '0;
    logic [W-1:0]   u_d [LAT];

    always @(posedge aclk) begin
        u_v    <= {u_v[LAT-2:0], op_a_tvalid & op_b_tvalid};
        u_d[0] <= real_to_f32(f32_to_real(op_a_tdata) + f32_to_real(op_b_tdata));
        for (int s = 1; s < LAT; s++) u_d[s] <= u_d[s-1];
    end

    assign op_result_tvalid = u_v[LAT-1] | force_valid;
    assign op_result_tdata  = u_d[LAT-1];

    // Operands per requester and their hand-computed sums.
    localparam logic [31:0] OPA [NR] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h3F800000};
    localparam logic [31:0] OPB [NR] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40000000};
    localparam logic [31:0] SUM [NR] = '{32'h40000000, 32'h40800000, 32'h40600000, 32'h40400000};

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic sample();
        @(negedge aclk);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        req_bus.req_valid = '0;
        next_cycle();
        next_cycle();
        aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NR-1:0] exp_rv;
        logic [NR-1:0] wrap_seq [4];
        wrap_seq = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};

        req_bus.req_a     = {OPA[3], OPA[2], OPA[1], OPA[0]};
        req_bus.req_b     = {OPB[3], OPB[2], OPB[1], OPB[0]};
        req_bus.req_valid = 4'b1111;

        // Reset held with every requester asking.
        next_cycle();
        sample();
        check("rst_ready",      req_bus.req_ready,  0);
        check("rst_resp_valid", req_bus.resp_valid, 0);
        check("rst_resp_data",  req_bus.resp_data,  0);
        check("rst_op_valid",   op_a_tvalid,        0);
        check("rst_err",        err_mismatch,       0);

        // Single issue from requester 2.
        next_cycle();
        aresetn = 1'b1;
        req_bus.req_valid = 4'b0100;
        sample();
        check("single_ready",  req_bus.req_ready, 4'b0100);
        check("single_op_vld", op_b_tvalid,       1);
        check("single_op_a",   op_a_tdata,        32'h3FC00000);
        check("single_op_b",   op_b_tdata,        32'h40000000);
        for (int c = 1; c <= 15; c++) begin
            next_cycle();
            if (c == 1) req_bus.req_valid = '0;
            sample();
            if (c == 1) begin
                check("idle_op_vld",  op_a_tvalid, 0);
                check("idle_op_a",    op_a_tdata,  0);
            end
            check("single_resp_valid", req_bus.resp_valid, (c == 13) ? 4'b0100 : 4'b0000);
            if (c >= 13) check("single_resp_data", req_bus.resp_data, 32'h40600000);
        end

        // Full contention from pointer 0 for 8 cycles.
        do_reset();
        req_bus.req_valid = 4'b1111;
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) next_cycle();
            if (c == 8) req_bus.req_valid = '0;
            sample();
            if (c < 8) check("rr_grant", req_bus.req_ready, 4'b0001 << (c % 4));
            exp_rv = (c >= 13 && c <= 20) ? 4'(4'b0001 << ((c - 13) % 4)) : 4'b0000;
            check("rr_resp_valid", req_bus.resp_valid, exp_rv);
            if (exp_rv != 0) check("rr_resp_data", req_bus.resp_data, SUM[(c - 13) % 4]);
        end

        // Move the pointer to 2, then requesters 1 and 3 alternate.
        next_cycle();
        req_bus.req_valid = 4'b0010;
        sample();
        check("ptr_setup", req_bus.req_ready, 4'b0010);
        next_cycle();
        req_bus.req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("wrap_grant", req_bus.req_ready, wrap_seq[k]);
            next_cycle();
        end
        req_bus.req_valid = '0;
        for (int k = 0; k < 16; k++) next_cycle();
        sample();
        check("wrap_err", err_mismatch, 0);

        // Five issues in flight, then a one-cycle reset pulse.
        next_cycle();
        req_bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            sample();
            next_cycle();
        end
        req_bus.req_valid = '0;
        aresetn = 1'b0;
        sample();
        check("midrst_ready", req_bus.req_ready, 0);
        next_cycle();
        aresetn = 1'b1;
        for (int c = 6; c <= 22; c++) begin
            sample();
            check("midrst_resp_valid", req_bus.resp_valid, 0);
            check("midrst_err",        err_mismatch,       0);
            next_cycle();
        end

        // Spurious unit result after the drain window.
        force_valid = 1'b1;
        sample();
        check("mm_err_before", err_mismatch, 0);
        next_cycle();
        force_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("mm_err_sticky",  err_mismatch,       1);
            check("mm_resp_valid",  req_bus.resp_valid, 0);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
